// File: rtl/fetch_stage.sv
// Instruction fetch stage with PA-RISC style delayed branching (PC/nPC pair)
// and an IF/ID pipeline register fed by a zero-latency instruction ROM.
module fetch_stage #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          le,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          nullify,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] npc_out,
  output logic [DW-1:0] ifid_instr,
  output logic [AW-1:0] ifid_pc,
  output logic          ifid_valid
);

  localparam logic [AW-1:0] WORD_STEP = AW'(4);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] npc_q, npc_d;
  logic [DW-1:0] ifid_instr_q, ifid_instr_d;
  logic [AW-1:0] ifid_pc_q, ifid_pc_d;
  logic          ifid_valid_q, ifid_valid_d;
  logic [AW-1:0] aligned_target;
  logic [AW-1:0] npc_seq;

  // Targets are forced to a word boundary so a misaligned address is never fetched.
  assign aligned_target = {branch_target[AW-1:2], 2'b00};
  assign npc_seq        = npc_q + WORD_STEP;

  always_comb begin
    pc_d         = pc_q;
    npc_d        = npc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;

    if (le) begin
      pc_d  = npc_q;
      npc_d = branch_taken ? aligned_target : npc_seq;
      if (!nullify) begin
        ifid_instr_d = rom_data;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
      end
    end

    // A flush wins over a stall: the delay-slot instruction is squashed even when frozen.
    if (nullify) begin
      ifid_instr_d = '0;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      npc_q        <= WORD_STEP;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign rom_addr   = pc_q;
  assign pc_out     = pc_q;
  assign npc_out    = npc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: each stimulus step pushes the
// hand-computed post-edge state; a negedge monitor pops and compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        le;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        nullify;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  pc_out;
  logic [7:0]  npc_out;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  npc;
    logic [31:0] instr;
    logic [7:0]  ipc;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  always #5 clk = ~clk;

  // ROM content: each word encodes its own byte address in the low byte.
  function automatic logic [31:0] w(input logic [7:0] a);
    return {24'h5A5A5A, a};
  endfunction

  assign rom_data = w(rom_addr);

  fetch_stage #(.AW(8), .DW(32)) dut (
    .clk(clk),
    .reset(reset),
    .le(le),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .nullify(nullify),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .pc_out(pc_out),
    .npc_out(npc_out),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL txn%0d %s: got %h want %h", txn, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      chk("pc", 32'(pc_out), 32'(e.pc));
      chk("npc", 32'(npc_out), 32'(e.npc));
      chk("rom_addr", 32'(rom_addr), 32'(e.pc));
      chk("ifid_instr", ifid_instr, e.instr);
      chk("ifid_pc", 32'(ifid_pc), 32'(e.ipc));
      chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
      $display("txn%0d pc=%h npc=%h ifid_pc=%h instr=%h valid=%0d",
               txn, pc_out, npc_out, ifid_pc, ifid_instr, ifid_valid);
    end
  end

  task automatic step(input logic r, input logic l, input logic b, input logic [7:0] t,
                      input logic n, input logic [7:0] epc, input logic [7:0] enpc,
                      input logic [31:0] ei, input logic [7:0] eipc, input logic ev);
    exp_t e;
    @(negedge clk);
    reset = r; le = l; branch_taken = b; branch_target = t; nullify = n;
    @(posedge clk);
    #1;
    e.pc = epc; e.npc = enpc; e.instr = ei; e.ipc = eipc; e.valid = ev;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; le = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; nullify = 1'b0;
    //   rst le bt tgt   nul  pc     npc    instr     ipc    v
    step(1, 0, 0, 8'h00, 0, 8'h00, 8'h04, 32'h0,    8'h00, 0);
    // sequential fetch
    step(0, 1, 0, 8'h00, 0, 8'h04, 8'h08, w(8'h00), 8'h00, 1);
    step(0, 1, 0, 8'h00, 0, 8'h08, 8'h0C, w(8'h04), 8'h04, 1);
    step(0, 1, 0, 8'h00, 0, 8'h0C, 8'h10, w(8'h08), 8'h08, 1);
    step(0, 1, 0, 8'h00, 0, 8'h10, 8'h14, w(8'h0C), 8'h0C, 1);
    // stall at 0x10; branch request while stalled is ignored
    step(0, 0, 0, 8'h00, 0, 8'h10, 8'h14, w(8'h0C), 8'h0C, 1);
    step(0, 0, 1, 8'h80, 0, 8'h10, 8'h14, w(8'h0C), 8'h0C, 1);
    step(0, 0, 0, 8'h00, 0, 8'h10, 8'h14, w(8'h0C), 8'h0C, 1);
    step(0, 1, 0, 8'h00, 0, 8'h14, 8'h18, w(8'h10), 8'h10, 1);
    step(0, 1, 0, 8'h00, 0, 8'h18, 8'h1C, w(8'h14), 8'h14, 1);
    step(0, 1, 0, 8'h00, 0, 8'h1C, 8'h20, w(8'h18), 8'h18, 1);
    step(0, 1, 0, 8'h00, 0, 8'h20, 8'h24, w(8'h1C), 8'h1C, 1);
    // nullify at 0x20: le=0 holds PC, then le=1 advances
    step(0, 0, 0, 8'h00, 1, 8'h20, 8'h24, 32'h0,    8'h00, 0);
    step(0, 1, 0, 8'h00, 1, 8'h24, 8'h28, 32'h0,    8'h00, 0);
    step(0, 1, 0, 8'h00, 0, 8'h28, 8'h2C, w(8'h24), 8'h24, 1);
    // delayed branch from reset state: PC=8,nPC=12 -> target 0x40
    step(1, 1, 1, 8'h20, 1, 8'h00, 8'h04, 32'h0,    8'h00, 0);
    step(0, 1, 0, 8'h00, 0, 8'h04, 8'h08, w(8'h00), 8'h00, 1);
    step(0, 1, 0, 8'h00, 0, 8'h08, 8'h0C, w(8'h04), 8'h04, 1);
    step(0, 1, 1, 8'h40, 0, 8'h0C, 8'h40, w(8'h08), 8'h08, 1);
    step(0, 1, 0, 8'h00, 0, 8'h40, 8'h44, w(8'h0C), 8'h0C, 1);
    // branch + nullify together
    step(0, 1, 1, 8'hF8, 1, 8'h44, 8'hF8, 32'h0,    8'h00, 0);
    step(0, 1, 0, 8'h00, 0, 8'hF8, 8'hFC, w(8'h44), 8'h44, 1);
    // nPC wrap 0xFC+4 -> 0x00
    step(0, 1, 0, 8'h00, 0, 8'hFC, 8'h00, w(8'hF8), 8'hF8, 1);
    // misaligned target 0x43 -> 0x40
    step(0, 1, 1, 8'h43, 0, 8'h00, 8'h40, w(8'hFC), 8'hFC, 1);
    step(0, 1, 0, 8'h00, 0, 8'h40, 8'h44, w(8'h00), 8'h00, 1);
    step(0, 1, 1, 8'h80, 0, 8'h44, 8'h80, w(8'h40), 8'h40, 1);
    step(0, 1, 0, 8'h00, 0, 8'h80, 8'h84, w(8'h44), 8'h44, 1);
    // reset during stall with branch pending at PC=0x80
    step(1, 0, 1, 8'h10, 0, 8'h00, 8'h04, 32'h0,    8'h00, 0);
    // first fetch after reset is address 0
    step(0, 1, 0, 8'h00, 0, 8'h04, 8'h08, w(8'h00), 8'h00, 1);

    le = 1'b0; branch_taken = 1'b0; nullify = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter AW, default 8, instruction address width (bytes; matches the 256-byte instruction ROM).
REQ-002 SHALL have parameter DW, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port le  input  1  load enable; 0 = stall (PC, nPC and IF/ID hold).
REQ-006 SHALL have port branch_taken  input  1  redirect request from the downstream branch logic.
REQ-007 SHALL have port branch_target  input  AW  byte address of the branch target.
REQ-008 SHALL have port nullify  input  1  flush IF/ID (PA-RISC nullification of the delay-slot instruction).
REQ-009 SHALL have port rom_addr  output  AW  byte address driven to the instruction ROM address input.
REQ-010 SHALL have port rom_data  input  DW  big-endian instruction word returned combinationally by the ROM.
REQ-011 SHALL have port pc_out  output  AW  current PC register.
REQ-012 SHALL have port npc_out  output  AW  current nPC register.
REQ-013 SHALL have port ifid_instr  output  DW  latched instruction for decode.
REQ-014 SHALL have port ifid_pc  output  AW  PC of the latched instruction.
REQ-015 SHALL have port ifid_valid  output  1  latched instruction is live (not bubble or nullified).

Function
REQ-016 SHALL drive rom_addr = PC combinationally; zero-cycle ROM read, so fetch latency is 1 clock to IF/ID.
REQ-017 SHALL implement PA-RISC delayed branching: when le=1, PC <= nPC; nPC <= branch_taken ? {branch_target[AW-1:2],2'b00} : nPC+4.
REQ-018 SHALL force branch_target[1:0] to 00 (word alignment); misaligned targets are never fetched.
REQ-019 SHALL compute nPC+4 modulo 2^AW (252+4 -> 0 at AW=8); no overflow flag, no exception.
REQ-020 SHALL ignore branch_taken while le=0; the requester holds it until a cycle with le=1.
REQ-021 SHALL, when le=1 and nullify=0, load ifid_instr <= rom_data, ifid_pc <= PC, ifid_valid <= 1.
REQ-022 SHALL, when nullify=1, load ifid_instr <= 0 (NOP), ifid_pc <= 0, ifid_valid <= 0, regardless of le.
REQ-023 SHALL, when nullify=1 and le=1, still advance PC/nPC per REQ-017; when nullify=1 and le=0, hold PC/nPC.
REQ-024 SHALL, when le=0 and nullify=0, hold PC, nPC and all IF/ID outputs unchanged.
REQ-025 SHALL, when branch_taken and nullify are asserted together with le=1, apply both: redirect nPC and flush IF/ID in the same edge.
REQ-026 SHALL have no combinational path from any input to any output except rom_data-free rom_addr = PC.

Reset
REQ-027 SHALL, on a rising clk with reset=1, set PC=0, nPC=4, ifid_instr=0, ifid_pc=0, ifid_valid=0.
REQ-028 SHALL give reset priority over le, nullify and branch_taken, including mid-stall and mid-branch.
REQ-029 SHALL fetch address 0 on the first edge after reset deasserts (ifid_pc=0, ifid_valid=1 one cycle later).

Verification
REQ-030 Sequential fetch: reset, le=1 for 4 cycles, ROM words W0..W3 -> ifid_pc 0,4,8,12; ifid_instr W0..W3; nPC 8,12,16,20.
REQ-031 Delayed branch: at PC=8,nPC=12 assert branch_taken, target=0x40 for 1 cycle -> next PC=12, nPC=0x40; following PC=0x40, nPC=0x44.
REQ-032 Stall: le=0 for 3 cycles at PC=0x10 -> PC, nPC, ifid_* unchanged; le=1 resumes with ifid_pc=0x10.
REQ-033 Nullify: nullify=1 with le=1 at PC=0x20 -> ifid_instr=0, ifid_valid=0, PC advances to 0x24; with le=0 -> PC stays 0x20.
REQ-034 Wrap and alignment: PC=0xF8,nPC=0xFC, le=1 -> nPC=0x00; branch_target=0x43 -> nPC=0x40.
REQ-035 Reset mid-operation: reset=1 during stall with branch_taken=1 at PC=0x80 -> PC=0, nPC=4, ifid_valid=0 after the edge.
